// File: rtl/multiplier_seq_if.sv
// Handshake and data bundle for the sequential Booth multiplier.
// The master drives the request side; the slave (the multiplier) drives status and result.
interface multiplier_seq_if;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic [127:0] result;
    logic         op_done;
    logic [2:0]   state;
    logic [6:0]   count;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  result, op_done, state, count
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output result, op_done, state, count
    );
endinterface

// File: rtl/multiplier_seq.sv
// Radix-2 Booth signed 64x64 -> 128 multiplier, one Booth step per clock.
// Upper half is kept 65 bits wide so A = -2^63 never overflows the add/subtract.
module multiplier_seq (
    input logic            clk,
    input logic            reset,
    multiplier_seq_if.slave bus
);
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 7;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        EXEC = 3'b001,
        DONE = 3'b010
    } state_t;

    state_t          state_q, state_n;
    logic [W:0]      hi_q, hi_n;
    logic [W-1:0]    lo_q, lo_n;
    logic [W-1:0]    mcand_q, mcand_n;
    logic [W-1:0]    mplier_q, mplier_n;
    logic            prior_q, prior_n;
    logic [CW-1:0]   count_q, count_n;
    logic [W:0]      addend;
    logic [W:0]      sum;
    logic            bit_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prior_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            prior_q  <= prior_n;
            count_q  <= count_n;
        end
    end

    // Next-state and Booth step; op_clear overrides normal sequencing
    always_comb begin
        state_n  = state_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        mcand_n  = mcand_q;
        mplier_n = mplier_q;
        prior_n  = prior_q;
        count_n  = count_q;
        addend   = {mcand_q[W-1], mcand_q};
        sum      = hi_q;
        bit_c    = mplier_q[count_q[5:0]];

        if (bus.op_clear) begin
            state_n  = IDLE;
            hi_n     = '0;
            lo_n     = '0;
            mcand_n  = '0;
            mplier_n = '0;
            prior_n  = 1'b0;
            count_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_start) begin
                        mcand_n  = bus.multiplicand;
                        mplier_n = bus.multiplier;
                        hi_n     = '0;
                        lo_n     = '0;
                        prior_n  = 1'b0;
                        count_n  = '0;
                        state_n  = EXEC;
                    end
                end
                EXEC: begin
                    // One extra cycle after the last step to enter DONE
                    if (count_q == CW'(W)) begin
                        state_n = DONE;
                    end else begin
                        case ({bit_c, prior_q})
                            2'b10:   sum = hi_q - addend;
                            2'b01:   sum = hi_q + addend;
                            default: sum = hi_q;
                        endcase
                        hi_n    = {sum[W], sum[W:1]};
                        lo_n    = {sum[0], lo_q[W-1:1]};
                        prior_n = bit_c;
                        count_n = count_q + CW'(1);
                    end
                end
                DONE: begin
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.result  = {hi_q[W-1:0], lo_q};
    assign bus.op_done = (state_q == DONE);
    assign bus.state   = state_q;
    assign bus.count   = count_q;
endmodule
